alu_exec_stage: RTL

Registered execute stage around the existing `alu`. It accepts operand/opcode requests over a valid/ready handshake, evaluates them through one `alu` instance, and presents the result and flags in a single-entry output register with its own valid/ready handshake. It sits between operand fetch (upstream) and writeback (downstream). An optional iterative shift-and-add multiplier reuses the same `alu` adder.

---
 rtl/alu_types.sv | 24 ++
 rtl/alu.sv | 52 +++++
 rtl/alu_exec_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_types.sv
// Shared ALU types: operation encoding, execute-stage FSM states and
// the iteration count of the shift-and-add multiplier.
package alu_types;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_control_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } exec_state_t;

  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = $clog2(MUL_ITERS);

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic, signed compare and shifts, with
// signed overflow, zero-result and operand-equality flags. Zero latency.
module alu
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  alu_control_t  control,
  output logic [N-1:0]  result,
  output logic          overflow,
  output logic          zero,
  output logic          equal
);

  localparam int SH_W = $clog2(N);

  logic [N-1:0]    sum;
  logic [N-1:0]    diff;
  logic [SH_W-1:0] shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

  assign zero  = (result == '0);
  assign equal = (a == b);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage around one alu: 1-cycle ops, optional 32-cycle multiply
// (ALU_EXEC_MUL_EN); in_ready drops while the output register is held or a multiply runs.
module alu_exec_stage
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  alu_control_t  in_control,
  input  logic          in_mul,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic          out_overflow,
  output logic          out_zero,
  output logic          out_equal,
  output logic          sticky_overflow,
  input  logic          clear_sticky,
  output logic          busy
);

  logic [N-1:0] alu_a, alu_b, alu_result;
  alu_control_t alu_control;
  logic         alu_overflow, alu_zero, alu_equal;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  logic         out_overflow_q, out_overflow_d;
  logic         out_zero_q, out_zero_d;
  logic         out_equal_q, out_equal_d;
  logic         sticky_q, sticky_d;
  logic         idle, accept, req_mul;

  alu #(.N(N)) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .control  (alu_control),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .equal    (alu_equal)
  );

`ifdef ALU_EXEC_MUL_EN
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_ITERS - 1);

  exec_state_t            state_q, state_d;
  logic [N-1:0]           acc_q, acc_d;
  logic [N-1:0]           mcand_q, mcand_d;
  logic [N-1:0]           mplier_q, mplier_d;
  logic                   eq_q, eq_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;

  assign idle    = (state_q == S_IDLE);
  assign busy    = (state_q == S_MUL);
  assign req_mul = in_mul;

  // The multiplier borrows the alu adder for acc + mcand.
  assign alu_a       = busy ? acc_q   : in_a;
  assign alu_b       = busy ? mcand_q : in_b;
  assign alu_control = busy ? ALU_ADD : in_control;
`else
  logic unused_in_mul;

  assign unused_in_mul = in_mul;
  assign idle          = 1'b1;
  assign busy          = 1'b0;
  assign req_mul       = 1'b0;
  assign alu_a         = in_a;
  assign alu_b         = in_b;
  assign alu_control   = in_control;
`endif

  assign in_ready = !rst && idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_zero_d     = out_zero_q;
    out_equal_d    = out_equal_q;
    // Set wins over clear when both land on the same edge.
    sticky_d       = (sticky_q && !clear_sticky) || (out_valid_q && out_ready && out_overflow_q);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept && !req_mul) begin
      out_valid_d    = 1'b1;
      out_result_d   = alu_result;
      out_overflow_d = alu_overflow;
      out_zero_d     = alu_zero;
      out_equal_d    = alu_equal;
    end

`ifdef ALU_EXEC_MUL_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    eq_d     = eq_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && req_mul) begin
          acc_d    = '0;
          mcand_d  = in_a;
          mplier_d = in_b;
          eq_d     = (in_a == in_b);
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + MUL_CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          out_valid_d    = 1'b1;
          out_result_d   = acc_d;
          out_overflow_d = 1'b0;
          out_zero_d     = (acc_d == '0);
          out_equal_d    = eq_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_equal_q    <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
      out_equal_q    <= out_equal_d;
      sticky_q       <= sticky_d;
    end
  end

`ifdef ALU_EXEC_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      eq_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      eq_q     <= eq_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_overflow    = out_overflow_q;
  assign out_zero        = out_zero_q;
  assign out_equal       = out_equal_q;
  assign sticky_overflow = sticky_q;

endmodule
